// File: rtl/sample_scheduler_if.sv
// Bundles the control, strobe and status signals between the scheduler and the
// read/write drivers and checker.
interface sample_scheduler_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic             start;
  logic [CNT_W-1:0] vector_len;
  logic             mismatch;
  logic             read_stb;
  logic             write_stb;
  logic [CNT_W-1:0] sample_idx;
  logic             busy;
  logic             done;
  logic             test_passed;
  logic [CNT_W-1:0] error_cnt;

  // Master issues requests and reports mismatches; slave is the scheduler.
  modport master (
    output start, vector_len, mismatch,
    input  read_stb, write_stb, sample_idx, busy, done, test_passed, error_cnt
  );

  modport slave (
    input  start, vector_len, mismatch,
    output read_stb, write_stb, sample_idx, busy, done, test_passed, error_cnt
  );

endinterface

// File: rtl/sample_scheduler.sv
// Sequences one test-vector run: single-cycle read/write strobes every DIV
// clocks, sample counting, and sticky pass/fail with a saturating error count.
module sample_scheduler #(
  parameter int unsigned DUT_CLK_FREQ = 100_000_000,
  parameter int unsigned SAMPLE_FREQ  = 25_000_000,
  parameter int unsigned WRITE_OFFSET = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                clk,
  input  logic                rst,
  sample_scheduler_if.slave   bus
);

  localparam int unsigned DIV     = (SAMPLE_FREQ == 0) ? 0 : DUT_CLK_FREQ / SAMPLE_FREQ;
  localparam int unsigned PHASE_W = (DIV > 2) ? $clog2(DIV) : 1;

  if (SAMPLE_FREQ == 0 || (DUT_CLK_FREQ % SAMPLE_FREQ) != 0 || DIV < 2) begin : g_bad_div
    $error("sample_scheduler: DUT_CLK_FREQ/SAMPLE_FREQ must be an integer >= 2");
  end
  if (WRITE_OFFSET < 1 || WRITE_OFFSET > DIV - 1) begin : g_bad_offset
    $error("sample_scheduler: WRITE_OFFSET must lie in 1..DIV-1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q,       state_d;
  logic [CNT_W-1:0]   len_q,         len_d;
  logic [CNT_W-1:0]   rd_cnt_q,      rd_cnt_d;
  logic [CNT_W-1:0]   wr_cnt_q,      wr_cnt_d;
  logic [PHASE_W-1:0] phase_q,       phase_d;
  logic               read_stb_q,    read_stb_d;
  logic               write_stb_q,   write_stb_d;
  logic [CNT_W-1:0]   sample_idx_q,  sample_idx_d;
  logic               busy_q,        busy_d;
  logic               done_q,        done_d;
  logic               test_passed_q, test_passed_d;
  logic [CNT_W-1:0]   error_cnt_q,   error_cnt_d;

  // Counter values for the coming cycle, accounting for strobes issued this cycle.
  logic [CNT_W-1:0]   rd_cnt_n;
  logic [CNT_W-1:0]   wr_cnt_n;
  logic [PHASE_W-1:0] phase_n;

  always_comb begin
    rd_cnt_n = rd_cnt_q + CNT_W'(read_stb_q);
    wr_cnt_n = wr_cnt_q + CNT_W'(write_stb_q);
    phase_n  = (phase_q == PHASE_W'(DIV - 1)) ? '0 : phase_q + PHASE_W'(1);
  end

  // Next-state and registered-output logic; strobes default low every cycle.
  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    rd_cnt_d      = rd_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    phase_d       = phase_q;
    read_stb_d    = 1'b0;
    write_stb_d   = 1'b0;
    sample_idx_d  = sample_idx_q;
    busy_d        = busy_q;
    done_d        = done_q;
    test_passed_d = test_passed_q;
    error_cnt_d   = error_cnt_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          test_passed_d = 1'b1;
          error_cnt_d   = '0;
          if (bus.vector_len != '0) begin
            // Sample 0 is read in the very first RUN cycle.
            state_d      = S_RUN;
            len_d        = bus.vector_len;
            rd_cnt_d     = '0;
            wr_cnt_d     = '0;
            phase_d      = '0;
            read_stb_d   = 1'b1;
            sample_idx_d = '0;
            busy_d       = 1'b1;
            done_d       = 1'b0;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      S_RUN: begin
        rd_cnt_d = rd_cnt_n;
        wr_cnt_d = wr_cnt_n;
        phase_d  = phase_n;

        if (write_stb_q && bus.mismatch) begin
          test_passed_d = 1'b0;
          if (error_cnt_q != '1) begin
            error_cnt_d = error_cnt_q + CNT_W'(1);
          end
        end

        if (wr_cnt_n == len_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          read_stb_d  = (phase_n == '0) && (rd_cnt_n < len_q);
          write_stb_d = (phase_n == PHASE_W'(WRITE_OFFSET)) && (wr_cnt_n < rd_cnt_n);
          if (read_stb_d) begin
            sample_idx_d = rd_cnt_n;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      rd_cnt_q      <= '0;
      wr_cnt_q      <= '0;
      phase_q       <= '0;
      read_stb_q    <= 1'b0;
      write_stb_q   <= 1'b0;
      sample_idx_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      test_passed_q <= 1'b1;
      error_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      rd_cnt_q      <= rd_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      phase_q       <= phase_d;
      read_stb_q    <= read_stb_d;
      write_stb_q   <= write_stb_d;
      sample_idx_q  <= sample_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      test_passed_q <= test_passed_d;
      error_cnt_q   <= error_cnt_d;
    end
  end

  assign bus.read_stb    = read_stb_q;
  assign bus.write_stb   = write_stb_q;
  assign bus.sample_idx  = sample_idx_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.test_passed = test_passed_q;
  assign bus.error_cnt   = error_cnt_q;

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: two configurations (DIV=4/OFFSET=2/CNT_W=16 and
// DIV=2/OFFSET=1/CNT_W=2), expected events scheduled from the timing rules.
module tb_sample_scheduler;

  localparam int K_RD   = 0;
  localparam int K_WR   = 1;
  localparam int K_DONE = 2;
  localparam int K_RST  = 3;

  localparam int MM_ZERO = 0;
  localparam int MM_ONE  = 1;
  localparam int MM_RAND = 2;
  localparam int MM_PLAN = 3;

  typedef struct {
    int kind;
    int cyc;
    int idx;
    int err;
    int pass;
  } ev_t;

  logic        clk = 1'b0;
  logic        drv_rst = 1'b1;
  logic        sel = 1'b0;
  logic        drv_start = 1'b0;
  logic [15:0] drv_len = '0;
  logic        drv_mm = 1'b0;
  logic        mon_on = 1'b0;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int cfg_div, cfg_wo, cfg_sat, cfg_maxlen;
  ev_t exp_q[$];

  sample_scheduler_if #(.CNT_W(16)) bus_a ();
  sample_scheduler_if #(.CNT_W(2))  bus_b ();

  sample_scheduler #(
    .DUT_CLK_FREQ(100_000_000), .SAMPLE_FREQ(25_000_000), .WRITE_OFFSET(2), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(drv_rst), .bus(bus_a)
  );

  sample_scheduler #(
    .DUT_CLK_FREQ(50_000_000), .SAMPLE_FREQ(25_000_000), .WRITE_OFFSET(1), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(drv_rst), .bus(bus_b)
  );

  assign bus_a.start      = ~sel & drv_start;
  assign bus_a.vector_len = drv_len;
  assign bus_a.mismatch   = ~sel & drv_mm;
  assign bus_b.start      = sel & drv_start;
  assign bus_b.vector_len = drv_len[1:0];
  assign bus_b.mismatch   = sel & drv_mm;

  logic        o_rd, o_wr, o_busy, o_done, o_pass;
  logic [15:0] o_idx, o_err;
  assign o_rd   = sel ? bus_b.read_stb    : bus_a.read_stb;
  assign o_wr   = sel ? bus_b.write_stb   : bus_a.write_stb;
  assign o_busy = sel ? bus_b.busy        : bus_a.busy;
  assign o_done = sel ? bus_b.done        : bus_a.done;
  assign o_pass = sel ? bus_b.test_passed : bus_a.test_passed;
  assign o_idx  = sel ? 16'(bus_b.sample_idx) : bus_a.sample_idx;
  assign o_err  = sel ? 16'(bus_b.error_cnt)  : bus_a.error_cnt;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (cfg %0d, cycle %0d): got %0d, expected %0d", name, sel, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scheduled event whenever a strobe appears or an event is due.
  always @(negedge clk) begin
    ev_t e;
    bit  hit;
    if (mon_on) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        chk("event_overdue", cyc, exp_q[0].cyc);
        void'(exp_q.pop_front());
      end
      if (o_rd || o_wr) begin
        chk("rd_wr_overlap", int'(o_rd && o_wr), 0);
        hit = exp_q.size() > 0 && exp_q[0].cyc == cyc &&
              exp_q[0].kind == (o_rd ? K_RD : K_WR);
        if (o_rd) chk("read_stb_timing", int'(hit), 1);
        else      chk("write_stb_timing", int'(hit), 1);
        if (hit) begin
          e = exp_q.pop_front();
          if (o_rd) chk("sample_idx", int'(o_idx), e.idx);
          chk("busy_during_run", int'(o_busy), 1);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        case (e.kind)
          K_RD: chk("read_stb_missing", int'(o_rd), 1);
          K_WR: chk("write_stb_missing", int'(o_wr), 1);
          K_DONE: begin
            chk("done", int'(o_done), 1);
            chk("busy_at_done", int'(o_busy), 0);
            chk("error_cnt", int'(o_err), e.err);
            chk("test_passed", int'(o_pass), e.pass);
          end
          default: begin
            chk("rst_sample_idx", int'(o_idx), 0);
            chk("rst_busy", int'(o_busy), 0);
            chk("rst_done", int'(o_done), 0);
            chk("rst_test_passed", int'(o_pass), 1);
            chk("rst_error_cnt", int'(o_err), 0);
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int kind, input int c, input int idx, input int err, input int pass);
    ev_t e;
    e.kind = kind; e.cyc = c; e.idx = idx; e.err = err; e.pass = pass;
    exp_q.push_back(e);
  endtask

  // Reset held for one cycle; everything still pending after it is cancelled.
  task automatic do_reset();
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc > cyc) exp_q.delete(i);
    end
    drv_rst   = 1'b1;
    drv_start = 1'b0;
    drv_mm    = 1'b0;
    push_ev(K_RST, cyc + 1, 0, 0, 1);
    step();
    drv_rst = 1'b0;
  endtask

  // One run: start issued in the current cycle; returns in the first DONE
  // cycle (or right after an injected reset), then idles for `gap` cycles.
  task automatic run(input int len, input int mode, input int spur_rel,
                     input int rst_rel_in, input int gap, input bit rnd);
    int c, w_rel, errs, rst_rel;
    bit mm[$];
    c       = cyc;
    w_rel   = (len == 0) ? 0 : 1 + (len - 1) * cfg_div + cfg_wo;
    rst_rel = rst_rel_in;
    if (rnd && len > 0 && ($urandom % 6) == 0) rst_rel = $urandom_range(1, w_rel);
    for (int r = 0; r <= w_rel; r++) begin
      case (mode)
        MM_ZERO: mm.push_back(1'b0);
        MM_ONE:  mm.push_back(1'b1);
        MM_PLAN: mm.push_back(r == 7 || r == 8);
        default: mm.push_back(1'($urandom % 3 == 0));
      endcase
    end
    errs = 0;
    for (int k = 0; k < len; k++) begin
      push_ev(K_RD, c + 1 + k * cfg_div, k, 0, 0);
      push_ev(K_WR, c + 1 + k * cfg_div + cfg_wo, 0, 0, 0);
      if (mm[1 + k * cfg_div + cfg_wo]) errs++;
    end
    push_ev(K_DONE, c + w_rel + 1, 0, (errs > cfg_sat) ? cfg_sat : errs, int'(errs == 0));

    drv_start = 1'b1;
    drv_len   = 16'(len);
    drv_mm    = mm[0];
    for (int r = 1; r <= w_rel; r++) begin
      step();
      drv_start = (r == spur_rel) || (rnd && ($urandom % 7) == 0);
      drv_len   = 16'($urandom);
      drv_mm    = mm[r];
      if (r == rst_rel) begin
        do_reset();
        for (int g = 0; g < gap; g++) step();
        return;
      end
    end
    step();
    drv_start = 1'b0;
    drv_mm    = 1'($urandom % 2);
    for (int g = 0; g < gap; g++) begin
      step();
      drv_mm = 1'($urandom % 2);
    end
  endtask

  task automatic random_runs(input int n);
    for (int i = 0; i < n; i++) begin
      run($urandom_range(0, cfg_maxlen), MM_RAND, -1, -1, $urandom_range(0, 3), 1'b1);
    end
  endtask

  initial begin
    cfg_div = 4; cfg_wo = 2; cfg_sat = 65535; cfg_maxlen = 7;
    step();
    step();
    mon_on = 1'b1;
    do_reset();
    step();

    run(3, MM_ZERO, -1, -1, 2, 1'b0);
    run(4, MM_PLAN, -1, -1, 0, 1'b0);
    run(0, MM_ZERO, -1, -1, 0, 1'b0);
    run(2, MM_RAND, 3, -1, 1, 1'b0);
    run(5, MM_RAND, -1, 6, 2, 1'b0);
    random_runs(40);
    step();

    sel = 1'b1;
    cfg_div = 2; cfg_wo = 1; cfg_sat = 3; cfg_maxlen = 3;
    do_reset();
    step();
    run(3, MM_ONE, -1, -1, 0, 1'b0);
    run(2, MM_ZERO, -1, -1, 1, 1'b0);
    run(2, MM_ZERO, -1, -1, 0, 1'b0);
    run(0, MM_ZERO, -1, -1, 0, 1'b0);
    random_runs(40);

    for (int i = 0; i < 4; i++) step();
    chk("events_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
